lstm_cell_bp: RTL and testbench

LSTM_CELL_BP -- requirements
Module: lstm_cell_bp

---
 rtl/lstm_cell_bp_pkg.sv | 38 +++
 rtl/lstm_cell_bp_if.sv | 32 +++
 rtl/lstm_cell_bp_fxp_mul.sv | 33 +++
 rtl/lstm_cell_bp.sv | 146 ++++++++++++++
 tb/tb_lstm_cell_bp.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/lstm_cell_bp_pkg.sv
// Shared constants, FSM encoding and step indices for the LSTM cell backward pass.
package lstm_cell_bp_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_FRAC  = 24;

    // Q8.24 constants at the default word width
    localparam logic [31:0] FXP_ONE = 32'h0100_0000;
    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned STEP_W = 5;

    // One multiply per step, in this fixed order; S_COMMIT moves results to the outputs
    localparam logic [STEP_W-1:0] S_TC2    = 5'd0;
    localparam logic [STEP_W-1:0] S_DHO    = 5'd1;
    localparam logic [STEP_W-1:0] S_DC     = 5'd2;
    localparam logic [STEP_W-1:0] S_A2     = 5'd3;
    localparam logic [STEP_W-1:0] S_DCI    = 5'd4;
    localparam logic [STEP_W-1:0] S_DA     = 5'd5;
    localparam logic [STEP_W-1:0] S_IQ     = 5'd6;
    localparam logic [STEP_W-1:0] S_DCA    = 5'd7;
    localparam logic [STEP_W-1:0] S_DI     = 5'd8;
    localparam logic [STEP_W-1:0] S_FQ     = 5'd9;
    localparam logic [STEP_W-1:0] S_DCCP   = 5'd10;
    localparam logic [STEP_W-1:0] S_DF     = 5'd11;
    localparam logic [STEP_W-1:0] S_OQ     = 5'd12;
    localparam logic [STEP_W-1:0] S_DHTC   = 5'd13;
    localparam logic [STEP_W-1:0] S_DO     = 5'd14;
    localparam logic [STEP_W-1:0] S_DCP    = 5'd15;
    localparam logic [STEP_W-1:0] S_COMMIT = 5'd16;

endpackage

// File: rtl/lstm_cell_bp_if.sv
// Start/done handshake plus operand and result buses of the backward-pass cell.
interface lstm_cell_bp_if #(
    parameter int unsigned WIDTH = lstm_cell_bp_pkg::DEF_WIDTH
);
    logic                    i_start;
    logic signed [WIDTH-1:0] i_dh;
    logic signed [WIDTH-1:0] i_dc_next;
    logic signed [WIDTH-1:0] i_a;
    logic signed [WIDTH-1:0] i_i;
    logic signed [WIDTH-1:0] i_f;
    logic signed [WIDTH-1:0] i_o;
    logic signed [WIDTH-1:0] i_tanh_c;
    logic signed [WIDTH-1:0] i_prev_state;
    logic                    o_busy;
    logic                    o_done;
    logic signed [WIDTH-1:0] o_dc;
    logic signed [WIDTH-1:0] o_da;
    logic signed [WIDTH-1:0] o_di;
    logic signed [WIDTH-1:0] o_df;
    logic signed [WIDTH-1:0] o_do;
    logic signed [WIDTH-1:0] o_dc_prev;

    modport master (
        output i_start, i_dh, i_dc_next, i_a, i_i, i_f, i_o, i_tanh_c, i_prev_state,
        input  o_busy, o_done, o_dc, o_da, o_di, o_df, o_do, o_dc_prev
    );

    modport slave (
        input  i_start, i_dh, i_dc_next, i_a, i_i, i_f, i_o, i_tanh_c, i_prev_state,
        output o_busy, o_done, o_dc, o_da, o_di, o_df, o_do, o_dc_prev
    );
endinterface

// File: rtl/lstm_cell_bp_fxp_mul.sv
// Combinational signed Q-format multiply: full product, floor shift, saturate.
module fxp_mul
    import lstm_cell_bp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FRAC  = DEF_FRAC
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] prod_c
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    logic signed [PW-1:0] full;
    logic signed [PW-1:0] sh;

    // Arithmetic shift floors toward -inf; clamp when the upper bits are not a sign extension
    always_comb begin
        ax   = {{WIDTH{a[WIDTH-1]}}, a};
        bx   = {{WIDTH{b[WIDTH-1]}}, b};
        full = ax * bx;
        sh   = full >>> FRAC;
        if ((&sh[PW-1:WIDTH-1]) || !(|sh[PW-1:WIDTH-1])) begin
            prod_c = sh[WIDTH-1:0];
        end else begin
            prod_c = sh[PW-1] ? MIN_W : MAX_W;
        end
    end
endmodule

// File: rtl/lstm_cell_bp.sv
// LSTM cell backward step: 16 sequential multiplies through one shared fxp_mul.
module lstm_cell_bp
    import lstm_cell_bp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FRAC  = DEF_FRAC
) (
    input logic         clk,
    input logic         rst,
    lstm_cell_bp_if.slave bus
);
    localparam logic signed [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] sat_w(input logic [WIDTH:0] s);
        if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? MIN_W : MAX_W;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return sat_w({x[WIDTH-1], x} + {y[WIDTH-1], y});
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return sat_w({x[WIDTH-1], x} - {y[WIDTH-1], y});
    endfunction

    state_t              state_q, state_d;
    logic                accept_c, commit_c;
    logic [STEP_W-1:0]   cnt_q;
    logic signed [WIDTH-1:0] dh_q, dcn_q, a_q, i_q, f_q, o_q, tc_q, cp_q;
    logic signed [WIDTH-1:0] t1_q, t2_q, dc_s, da_s, di_s, df_s, do_s, dcp_s;
    logic signed [WIDTH-1:0] dc_q, da_q, di_q, df_q, do_q, dcp_q;
    logic                busy_q, done_q;
    logic signed [WIDTH-1:0] op_a_c, op_b_c, prod_c;

    fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (.a(op_a_c), .b(op_b_c), .prod_c(prod_c));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: accept only while idle, finish on the commit step
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.i_start) begin
                state_d  = ST_RUN;
                accept_c = 1'b1;
            end
            ST_RUN: if (cnt_q == S_COMMIT) begin
                state_d  = ST_IDLE;
                commit_c = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand multiplexer feeding the shared multiplier
    always_comb begin
        op_a_c = '0;
        op_b_c = '0;
        case (cnt_q)
            S_TC2:  begin op_a_c = tc_q; op_b_c = tc_q; end
            S_DHO:  begin op_a_c = dh_q; op_b_c = o_q;  end
            S_A2:   begin op_a_c = a_q;  op_b_c = a_q;  end
            S_DCI:  begin op_a_c = dc_s; op_b_c = i_q;  end
            S_IQ:   begin op_a_c = i_q;  op_b_c = sat_sub(ONE_W, i_q); end
            S_DCA:  begin op_a_c = dc_s; op_b_c = a_q;  end
            S_FQ:   begin op_a_c = f_q;  op_b_c = sat_sub(ONE_W, f_q); end
            S_DCCP: begin op_a_c = dc_s; op_b_c = cp_q; end
            S_OQ:   begin op_a_c = o_q;  op_b_c = sat_sub(ONE_W, o_q); end
            S_DHTC: begin op_a_c = dh_q; op_b_c = tc_q; end
            S_DCP:  begin op_a_c = dc_s; op_b_c = f_q;  end
            S_DC, S_DA, S_DI, S_DF, S_DO: begin op_a_c = t2_q; op_b_c = t1_q; end
            default: ;
        endcase
    end

    // Input latch, step counter and scratch results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            {dh_q, dcn_q, a_q, i_q, f_q, o_q, tc_q, cp_q} <= '0;
            {t1_q, t2_q, dc_s, da_s, di_s, df_s, do_s, dcp_s} <= '0;
        end else if (accept_c) begin
            cnt_q <= '0;
            dh_q  <= bus.i_dh;
            dcn_q <= bus.i_dc_next;
            a_q   <= bus.i_a;
            i_q   <= bus.i_i;
            f_q   <= bus.i_f;
            o_q   <= bus.i_o;
            tc_q  <= bus.i_tanh_c;
            cp_q  <= bus.i_prev_state;
        end else if (state_q == ST_RUN) begin
            cnt_q <= commit_c ? '0 : cnt_q + STEP_W'(1);
            case (cnt_q)
                S_TC2, S_A2:                  t1_q <= sat_sub(ONE_W, prod_c);
                S_IQ, S_FQ, S_OQ:             t1_q <= prod_c;
                S_DHO, S_DCI, S_DCA, S_DCCP, S_DHTC: t2_q <= prod_c;
                S_DC:  dc_s  <= sat_add(prod_c, dcn_q);
                S_DA:  da_s  <= prod_c;
                S_DI:  di_s  <= prod_c;
                S_DF:  df_s  <= prod_c;
                S_DO:  do_s  <= prod_c;
                S_DCP: dcp_s <= prod_c;
                default: ;
            endcase
        end
    end

    // Output registers, busy flag and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {dc_q, da_q, di_q, df_q, do_q, dcp_q} <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_q == ST_RUN) && !commit_c;
            done_q <= commit_c;
            if (commit_c) begin
                dc_q  <= dc_s;
                da_q  <= da_s;
                di_q  <= di_s;
                df_q  <= df_s;
                do_q  <= do_s;
                dcp_q <= dcp_s;
            end
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_dc      = dc_q;
    assign bus.o_da      = da_q;
    assign bus.o_di      = di_q;
    assign bus.o_df      = df_q;
    assign bus.o_do      = do_q;
    assign bus.o_dc_prev = dcp_q;
endmodule

// File: tb/tb_lstm_cell_bp.sv
// Directed-vector bench for lstm_cell_bp with hand-computed Q8.24 results.
module tb_lstm_cell_bp;
    import lstm_cell_bp_pkg::*;

    typedef struct {
        logic [31:0] dh, dcn, a, i, f, o, tc, cp;
    } vec_t;

    typedef struct {
        logic [31:0] dc, da, di, df, dq, dcp;
    } res_t;

    localparam logic [31:0] HALF = 32'h0080_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lstm_cell_bp_if #(.WIDTH(32)) bus();
    lstm_cell_bp #(.WIDTH(32), .FRAC(24)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic signed [31:0] ma, mb, mp;
    fxp_mul #(.WIDTH(32), .FRAC(24)) u_mul_chk (.a(ma), .b(mb), .prod_c(mp));

    int checks = 0;
    int errors = 0;
    int lat;
    int ndone;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        bus.i_dh         = v.dh;
        bus.i_dc_next    = v.dcn;
        bus.i_a          = v.a;
        bus.i_i          = v.i;
        bus.i_f          = v.f;
        bus.i_o          = v.o;
        bus.i_tanh_c     = v.tc;
        bus.i_prev_state = v.cp;
    endtask

    task automatic check_out(input string tag, input res_t r);
        check({tag, ".dc"},      bus.o_dc,      r.dc);
        check({tag, ".da"},      bus.o_da,      r.da);
        check({tag, ".di"},      bus.o_di,      r.di);
        check({tag, ".df"},      bus.o_df,      r.df);
        check({tag, ".do"},      bus.o_do,      r.dq);
        check({tag, ".dc_prev"}, bus.o_dc_prev, r.dcp);
    endtask

    // Pulse (or hold) start, count edges to o_done; optionally swap inputs mid-run
    task automatic run(input string tag, input bit hold, input int alter_at, input vec_t alt, output int n);
        @(negedge clk);
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.i_start = 1'b0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) check({tag, ".busy_on"}, 32'(bus.o_busy), 32'd1);
            if (n == alter_at) set_in(alt);
            if (bus.o_done) break;
        end
        bus.i_start = 1'b0;
        check({tag, ".latency"}, 32'(n), 32'd17);
        check({tag, ".busy_off"}, 32'(bus.o_busy), 32'd0);
    endtask

    vec_t v_nom, v_pass, v_sat1, v_sat2, v_floor, v_mix;
    res_t r_nom, r_pass, r_sat1, r_sat2, r_floor, r_mix, r_zero;

    initial begin
        v_nom   = '{FXP_ONE, 32'h0, 32'h0, HALF, HALF, HALF, 32'h0, 32'h0};
        r_nom   = '{HALF, 32'h0040_0000, 32'h0, 32'h0, 32'h0, 32'h0040_0000};
        v_pass  = '{32'h0, FXP_ONE, 32'h0, 32'h0, FXP_ONE, 32'h0, 32'h0, 32'h0};
        r_pass  = '{FXP_ONE, 32'h0, 32'h0, 32'h0, 32'h0, FXP_ONE};
        v_sat1  = '{SAT_MAX, FXP_ONE, 32'h0, 32'h0, 32'h0200_0000, FXP_ONE, 32'h0, 32'h0};
        r_sat1  = '{SAT_MAX, 32'h0, 32'h0, 32'h0, 32'h0, SAT_MAX};
        v_sat2  = '{SAT_MIN, 32'hFF00_0000, 32'h0, 32'h0, 32'h0, FXP_ONE, 32'h0, 32'h0};
        r_sat2  = '{SAT_MIN, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        v_floor = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, HALF, 32'h0, 32'h0};
        r_floor = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        v_mix   = '{FXP_ONE, HALF, HALF, HALF, HALF, HALF, HALF, FXP_ONE};
        r_mix   = '{32'h00E0_0000, 32'h0054_0000, 32'h001C_0000, 32'h0038_0000, 32'h0020_0000, 32'h0070_0000};
        r_zero  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        rst = 1'b1;
        bus.i_start = 1'b0;
        set_in(v_nom);
        ma = 32'hFFFF_FFFF;
        mb = HALF;
        #12;
        check("rst.busy", 32'(bus.o_busy), 32'd0);
        check("rst.done", 32'(bus.o_done), 32'd0);
        check_out("rst", r_zero);
        check("mul.floor", mp, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_in(v_nom);
        run("nom", 1'b0, 0, v_nom, lat);
        check_out("nom", r_nom);

        // Start raised in the o_done cycle must be accepted
        check("restart.done_cycle", 32'(bus.o_done), 32'd1);
        set_in(v_pass);
        run("restart", 1'b0, 0, v_pass, lat);
        check_out("pass", r_pass);
        repeat (2) @(negedge clk);

        set_in(v_sat1);
        run("sat1", 1'b0, 0, v_sat1, lat);
        check_out("sat1", r_sat1);
        repeat (2) @(negedge clk);

        set_in(v_sat2);
        run("sat2", 1'b0, 0, v_sat2, lat);
        check_out("sat2", r_sat2);
        repeat (2) @(negedge clk);

        set_in(v_floor);
        run("floor", 1'b0, 0, v_floor, lat);
        check_out("floor", r_floor);
        repeat (2) @(negedge clk);

        set_in(v_mix);
        run("mix", 1'b0, 0, v_mix, lat);
        check_out("mix", r_mix);

        // Outputs hold until the next completion
        repeat (5) @(negedge clk);
        check("hold.done_low", 32'(bus.o_done), 32'd0);
        check("hold.dc", bus.o_dc, r_mix.dc);

        // Start held high through RUN: a single o_done
        set_in(v_nom);
        run("held", 1'b1, 0, v_nom, lat);
        check_out("held", r_nom);
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.o_done) ndone++;
        end
        check("held.extra_done", 32'(ndone), 32'd0);

        // Inputs changed mid-run must not disturb the result
        set_in(v_pass);
        run("alter", 1'b0, 5, v_nom, lat);
        check_out("alter", r_pass);
        repeat (2) @(negedge clk);

        // Abort with reset at step 8
        set_in(v_mix);
        @(negedge clk);
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort.busy", 32'(bus.o_busy), 32'd0);
        check("abort.done", 32'(bus.o_done), 32'd0);
        check_out("abort", r_zero);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.o_done) ndone++;
        end
        check("abort.no_done", 32'(ndone), 32'd0);
        set_in(v_nom);
        run("after_abort", 1'b0, 0, v_nom, lat);
        check_out("after_abort", r_nom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
